snn_output_spike_classifier: RTL and testbench
==============================================

// Module: snn_output_spike_classifier
// PURPOSE
// Sits directly downstream of the SNN core's output neuron layer. Counts
// output-layer spikes per neuron over a programmed window of timesteps,
// then picks the winning (most active) neuron by sequential argmax. It
// presents the class index, the winning count and a tie flag to the AXI
// config register block for software readback.
// PARAMETERS
// NUM_OUTPUTS  3   number of output-layer neurons (spike lanes), >=2
// CNT_WIDTH    16  width of each per-neuron spike counter (saturating)
// STEP_WIDTH   16  width of the timestep window length / step counter
// IDX_W        $clog2(NUM_OUTPUTS)  width of neuron index (localparam)
// PORTS
// clk           in   1           system clock (single clock domain)
// rst           in   1           asynchronous, active-high reset
// start         in   1           1-cycle pulse: begin a classification window
// num_steps     in   STEP_WIDTH  window length in timesteps; sampled on start
// step_valid    in   1           1-cycle pulse per SNN timestep from core
// spikes        in   NUM_OUTPUTS output spike vector, valid when step_valid=1
// rd_idx        in   IDX_W       counter select for software readback
// rd_count      out  CNT_WIDTH   counter[rd_idx], combinational; 0 if idx>=N
// busy          out  1           high in ACCUM and SCAN states
// done          out  1           1-cycle pulse when result is valid
// winner        out  IDX_W       index of neuron with highest count
// winner_count  out  CNT_WIDTH   spike count of winner
// tie           out  1           another neuron equals winner's count
// BEHAVIOUR
// - Reset (async, any state): FSM=IDLE; all counters, step counter, scan
//   index, busy, done, winner, winner_count, tie = 0.
// - FSM: IDLE -> ACCUM -> SCAN -> DONE -> IDLE.
// - IDLE: start=1 clears all counters, latches num_steps. Next state is ACCUM,
//   or SCAN if num_steps==0.
// - start is ignored while busy=1 or in DONE; no restart mid-window.
// - ACCUM: on step_valid=1, each counter[i] with spikes[i]=1 increments by 1.
//   Counters saturate at all-ones (no wrap). The step counter increments.
//   On the step_valid where step count == num_steps-1, that step is counted,
//   and the next state is SCAN.
// - step_valid outside ACCUM is ignored; spikes is ignored when step_valid=0.
// - SCAN: exactly NUM_OUTPUTS cycles, index k = 0..N-1, one per cycle.
//   k=0 loads best=counter[0], best_idx=0, tie=0.
//   Each later k: counter[k] > best replaces best and clears tie;
//   counter[k] == best sets tie.
//   Strictly-greater compare, so the lowest index wins ties.
// - DONE: done=1 for exactly one cycle. winner, winner_count and tie update
//   on the SCAN->DONE edge and hold until the next DONE. Then return to IDLE.
// - Latency: done is high in the cycle NUM_OUTPUTS+1 edges after the edge
//   that samples the final step_valid. With num_steps==0, done is high
//   NUM_OUTPUTS+1 edges after the start edge, with all results 0.
// - Counters hold after DONE for rd_count readback until the next start.
// - rd_count is a pure mux and is legal in any state.
// - All-zero counts: winner=0, winner_count=0, tie=1.
// TESTING
// 1 N=3, num_steps=4; spikes 3'b011,3'b010,3'b110,3'b010 ->
//   counts {1,4,1}; winner=1, winner_count=4, tie=0, done at +4 cycles.
// 2 Tie: num_steps=2, spikes 3'b101 twice -> winner=0, count=2, tie=1;
//   rd_count(2)=2.
// 3 num_steps=0 with start -> done after 4 cycles; winner=0, count=0, tie=1;
//   busy high 3 cycles.
// 4 CNT_WIDTH=4, num_steps=20, lane2 spikes every step -> counter[2]=15
//   (saturated); winner=2.
// 5 Second start pulse mid-ACCUM and step_valid during SCAN -> no effect on
//   counts or timing.
// 6 rst asserted mid-ACCUM -> all outputs 0 immediately (async). A later
//   start runs a clean window.

Source files
------------

// File: rtl/snn_output_spike_classifier.sv
// snn_output_spike_classifier
//   Counts output-layer spikes per neuron over a programmed window of SNN
//   timesteps, then runs a sequential argmax over the counters. It reports
//   the winning class index, the winner's count and a tie flag.
//
// Ports
//   clk, rst      single clock, asynchronous active-high reset
//   start         1-cycle pulse, begins a window (accepted only in IDLE)
//   num_steps     window length in timesteps, sampled on an accepted start
//   step_valid    1-cycle pulse per timestep; spikes is valid with it
//   spikes        one bit per output neuron
//   rd_idx        counter select for software readback
//   rd_count      counter[rd_idx], combinational, 0 for an out-of-range index
//   busy          high while accumulating or scanning
//   done          1-cycle pulse once winner/winner_count/tie are valid
//   winner        index of the most active neuron (lowest index on ties)
//   winner_count  spike count of the winner
//   tie           another neuron has the same count as the winner

// Per-lane saturating spike counter.
module snn_spike_lane_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (inc && (cnt != '1))    cnt <= cnt + 1'b1;
  end
endmodule

module snn_output_spike_classifier #(
  parameter  int NUM_OUTPUTS = 3,
  parameter  int CNT_WIDTH   = 16,
  parameter  int STEP_WIDTH  = 16,
  localparam int IDX_W       = $clog2(NUM_OUTPUTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [STEP_WIDTH-1:0]  num_steps,
  input  logic                   step_valid,
  input  logic [NUM_OUTPUTS-1:0] spikes,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [CNT_WIDTH-1:0]   rd_count,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       winner,
  output logic [CNT_WIDTH-1:0]   winner_count,
  output logic                   tie
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_DONE} state_t;

  state_t                              state;
  logic [STEP_WIDTH-1:0]               num_steps_q;
  logic [STEP_WIDTH-1:0]               step_cnt;
  logic [IDX_W-1:0]                    scan_k;
  logic [CNT_WIDTH-1:0]                best_cnt;
  logic [IDX_W-1:0]                    best_idx;
  logic                                best_tie;
  logic [NUM_OUTPUTS-1:0][CNT_WIDTH-1:0] cnt;

  logic                 start_ok;
  logic                 acc_step;
  logic                 last_step;
  logic                 scan_last;
  logic [CNT_WIDTH-1:0] scan_val;
  logic [CNT_WIDTH-1:0] nxt_best;
  logic [IDX_W-1:0]     nxt_idx;
  logic                 nxt_tie;

  assign start_ok  = (state == S_IDLE) && start;
  assign acc_step  = (state == S_ACCUM) && step_valid;
  assign last_step = acc_step && (step_cnt == num_steps_q - STEP_WIDTH'(1));
  assign scan_last = (scan_k == IDX_W'(NUM_OUTPUTS - 1));

  // Counters are cleared on an accepted start, so they hold their values
  // after DONE for software readback until the next window begins.
  genvar g;
  generate
    for (g = 0; g < NUM_OUTPUTS; g++) begin : g_lane
      snn_spike_lane_counter #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .inc (acc_step && spikes[g]),
        .cnt (cnt[g])
      );
    end
  endgenerate

  // Loop muxes keep out-of-range indices (non power-of-two N) well defined.
  always_comb begin
    rd_count = '0;
    scan_val = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_count = cnt[i];
      if (scan_k == IDX_W'(i)) scan_val = cnt[i];
    end
  end

  // One argmax step. Strictly-greater replacement keeps the lowest index on
  // equal counts; an equal count only raises the tie flag.
  always_comb begin
    nxt_best = best_cnt;
    nxt_idx  = best_idx;
    nxt_tie  = best_tie;
    if (scan_k == '0) begin
      nxt_best = scan_val;
      nxt_idx  = '0;
      nxt_tie  = 1'b0;
    end else if (scan_val > best_cnt) begin
      nxt_best = scan_val;
      nxt_idx  = scan_k;
      nxt_tie  = 1'b0;
    end else if (scan_val == best_cnt) begin
      nxt_tie  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      num_steps_q  <= '0;
      step_cnt     <= '0;
      scan_k       <= '0;
      best_cnt     <= '0;
      best_idx     <= '0;
      best_tie     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner       <= '0;
      winner_count <= '0;
      tie          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            num_steps_q <= num_steps;
            step_cnt    <= '0;
            scan_k      <= '0;
            busy        <= 1'b1;
            // An empty window skips straight to the scan of cleared counters.
            state       <= (num_steps == '0) ? S_SCAN : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (step_valid) begin
            step_cnt <= step_cnt + 1'b1;
            if (last_step) begin
              scan_k <= '0;
              state  <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          best_cnt <= nxt_best;
          best_idx <= nxt_idx;
          best_tie <= nxt_tie;
          if (scan_last) begin
            winner       <= nxt_idx;
            winner_count <= nxt_best;
            tie          <= nxt_tie;
            busy         <= 1'b0;
            state        <= S_DONE;
          end else begin
            scan_k <= scan_k + 1'b1;
          end
        end
        S_DONE: begin
          // Results settled on entry; announce them one cycle later.
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_output_spike_classifier.sv
module tb_snn_output_spike_classifier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_steps;
  logic        step_valid;
  logic [2:0]  spikes;
  logic [1:0]  rd_idx;
  logic [15:0] rd_count;
  logic        busy, done, tie;
  logic [1:0]  winner;
  logic [15:0] winner_count;

  // Narrow-counter instance for saturation, driven by the same stimulus.
  logic [3:0]  rd_count4;
  logic        busy4, done4, tie4;
  logic [1:0]  winner4;
  logic [3:0]  winner_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snn_output_spike_classifier #(.NUM_OUTPUTS(3), .CNT_WIDTH(16), .STEP_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps),
    .step_valid(step_valid), .spikes(spikes), .rd_idx(rd_idx),
    .rd_count(rd_count), .busy(busy), .done(done), .winner(winner),
    .winner_count(winner_count), .tie(tie)
  );

  snn_output_spike_classifier #(.NUM_OUTPUTS(3), .CNT_WIDTH(4), .STEP_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps),
    .step_valid(step_valid), .spikes(spikes), .rd_idx(rd_idx),
    .rd_count(rd_count4), .busy(busy4), .done(done4), .winner(winner4),
    .winner_count(winner_count4), .tie(tie4)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1; num_steps = n;
    tick();
    start = 1'b0;
  endtask

  task automatic do_step(input logic [2:0] s);
    step_valid = 1'b1; spikes = s;
    tick();
    step_valid = 1'b0; spikes = '0;
  endtask

  // Returns edges until done is seen (-1 on timeout). With noise set,
  // step_valid with all spikes is driven during the first two scan cycles.
  task automatic wait_done(input bit noise, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (noise && i <= 2) begin step_valid = 1'b1; spikes = 3'b111; end
      tick();
      step_valid = 1'b0; spikes = '0;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; num_steps = 0; step_valid = 0; spikes = 0; rd_idx = 0;
    tick(); tick();
    checks++;
    if ({busy, done, winner, winner_count, tie} !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%0b done=%0b win=%0d cnt=%0d tie=%0b, expected all 0",
                         busy, done, winner, winner_count, tie);
    end
    checks++;
    if (rd_count !== 16'd0) begin
      errors++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    do_start(16'd4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b expected 1", busy); end
    do_step(3'b011); do_step(3'b010); do_step(3'b110); do_step(3'b010);
    wait_done(1'b0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    checks++;
    if (winner !== 2'd1 || winner_count !== 16'd4 || tie !== 1'b0) begin
      errors++; $display("FAIL basic_result: got win=%0d cnt=%0d tie=%0b expected 1 4 0", winner, winner_count, tie);
    end
    rd_idx = 2'd0; #1;
    checks++;
    if (rd_count !== 16'd1) begin errors++; $display("FAIL basic_rd0: got %0d expected 1", rd_count); end
    rd_idx = 2'd1; #1;
    checks++;
    if (rd_count !== 16'd4) begin errors++; $display("FAIL basic_rd1: got %0d expected 4", rd_count); end
    rd_idx = 2'd2; #1;
    checks++;
    if (rd_count !== 16'd1) begin errors++; $display("FAIL basic_rd2: got %0d expected 1", rd_count); end
    rd_idx = 2'd3; #1;
    checks++;
    if (rd_count !== 16'd0) begin errors++; $display("FAIL basic_rd_oob: got %0d expected 0", rd_count); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %0b expected 0", done); end
  endtask

  task automatic test_tie();
    int lat;
    do_start(16'd2);
    do_step(3'b101); do_step(3'b101);
    wait_done(1'b0, lat);
    checks++;
    if (winner !== 2'd0 || winner_count !== 16'd2 || tie !== 1'b1) begin
      errors++; $display("FAIL tie_result: got win=%0d cnt=%0d tie=%0b expected 0 2 1", winner, winner_count, tie);
    end
    rd_idx = 2'd2; #1;
    checks++;
    if (rd_count !== 16'd2) begin errors++; $display("FAIL tie_rd2: got %0d expected 2", rd_count); end
    tick();
  endtask

  task automatic test_zero_steps();
    int lat, busy_cyc;
    lat = -1; busy_cyc = 0;
    do_start(16'd0);
    for (int i = 1; i <= 20; i++) begin
      if (busy) busy_cyc++;
      tick();
      if (done) begin lat = i; break; end
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL zero_latency: got %0d expected 4", lat); end
    checks++;
    if (busy_cyc !== 3) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 3", busy_cyc); end
    checks++;
    if (winner !== 2'd0 || winner_count !== 16'd0 || tie !== 1'b1) begin
      errors++; $display("FAIL zero_result: got win=%0d cnt=%0d tie=%0b expected 0 0 1", winner, winner_count, tie);
    end
    tick();
  endtask

  task automatic test_saturate();
    int lat;
    do_start(16'd20);
    for (int i = 0; i < 20; i++) do_step(3'b100);
    wait_done(1'b0, lat);
    checks++;
    if (winner4 !== 2'd2 || winner_count4 !== 4'd15 || tie4 !== 1'b0) begin
      errors++; $display("FAIL sat_result: got win=%0d cnt=%0d tie=%0b expected 2 15 0", winner4, winner_count4, tie4);
    end
    rd_idx = 2'd2; #1;
    checks++;
    if (rd_count4 !== 4'd15) begin errors++; $display("FAIL sat_rd2: got %0d expected 15", rd_count4); end
    checks++;
    if (winner !== 2'd2 || winner_count !== 16'd20) begin
      errors++; $display("FAIL wide_result: got win=%0d cnt=%0d expected 2 20", winner, winner_count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    do_start(16'd3);
    do_step(3'b001);
    start = 1'b1; num_steps = 16'd1;
    tick();
    start = 1'b0;
    do_step(3'b001);
    do_step(3'b010);
    wait_done(1'b1, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    checks++;
    if (winner !== 2'd0 || winner_count !== 16'd2 || tie !== 1'b0) begin
      errors++; $display("FAIL b2b_result: got win=%0d cnt=%0d tie=%0b expected 0 2 0", winner, winner_count, tie);
    end
    rd_idx = 2'd1; #1;
    checks++;
    if (rd_count !== 16'd1) begin errors++; $display("FAIL b2b_rd1: got %0d expected 1", rd_count); end
    rd_idx = 2'd2; #1;
    checks++;
    if (rd_count !== 16'd0) begin errors++; $display("FAIL b2b_rd2: got %0d expected 0", rd_count); end
    tick();
  endtask

  task automatic test_async_reset();
    int lat;
    do_start(16'd5);
    do_step(3'b111); do_step(3'b111);
    #2 rst = 1'b1;
    #1;
    rd_idx = 2'd0; #1;
    checks++;
    if ({busy, done, winner, winner_count, tie} !== '0) begin
      errors++; $display("FAIL areset_outputs: got busy=%0b win=%0d cnt=%0d tie=%0b expected all 0",
                         busy, winner, winner_count, tie);
    end
    checks++;
    if (rd_count !== 16'd0) begin errors++; $display("FAIL areset_rd0: got %0d expected 0", rd_count); end
    tick();
    rst = 1'b0;
    tick();
    do_start(16'd1);
    do_step(3'b010);
    wait_done(1'b0, lat);
    checks++;
    if (lat !== 4 || winner !== 2'd1 || winner_count !== 16'd1 || tie !== 1'b0) begin
      errors++; $display("FAIL post_reset_run: got lat=%0d win=%0d cnt=%0d tie=%0b expected 4 1 1 0",
                         lat, winner, winner_count, tie);
    end
    rd_idx = 2'd0; #1;
    checks++;
    if (rd_count !== 16'd0) begin errors++; $display("FAIL post_reset_rd0: got %0d expected 0", rd_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_zero_steps();
    test_saturate();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
